// File: rtl/mux_7seg_capture_pkg.sv
// Shared constants and types for the 7-segment display bus capture path.
// Segment codes are active-high {G..A} and are reused by the other segment decoders.
package mux_7seg_capture_pkg;

    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;

    localparam logic [3:0] DIG_BAD = 4'hF;

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DONE   = 2'd2
    } cap_state_t;

    typedef struct packed {
        logic [6:0] seg;
        logic [3:0] dig;
    } bus_sample_t;

    localparam bus_sample_t BUS_BLANK = '{seg: 7'h00, dig: 4'hF};

    // Index of the single set bit; only meaningful for one-hot inputs.
    function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
        case (oh)
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational 7-segment (active-high {G..A}) to BCD lookup with a valid flag.
module seg7_to_bcd
    import mux_7seg_capture_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] bcd_c,
    output logic       valid_c
);

    always_comb begin
        bcd_c   = DIG_BAD;
        valid_c = 1'b1;
        case (seg)
            SEG_0:   bcd_c = 4'd0;
            SEG_1:   bcd_c = 4'd1;
            SEG_2:   bcd_c = 4'd2;
            SEG_3:   bcd_c = 4'd3;
            SEG_4:   bcd_c = 4'd4;
            SEG_5:   bcd_c = 4'd5;
            SEG_6:   bcd_c = 4'd6;
            SEG_7:   bcd_c = 4'd7;
            SEG_8:   bcd_c = 4'd8;
            SEG_9:   bcd_c = 4'd9;
            default: valid_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/mux_7seg_capture.sv
// Receive side of the 4-digit multiplexed 7-segment bus: synchronizes, waits for a
// settled slot, captures once per slot and reconstructs the four displayed digits.
module mux_7seg_capture
    import mux_7seg_capture_pkg::*;
#(
    parameter int unsigned SETTLE_CYC  = 4,
    parameter int unsigned TIMEOUT_CYC = 16384,
    parameter int unsigned SEG_ACT_LOW = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg_in,
    input  logic [3:0]  dig_in,
    output logic [15:0] dig_val,
    output logic [3:0]  dig_ok,
    output logic        frame_done,
    output logic        pat_err,
    output logic        sel_err,
    output logic        stale
);

    localparam int unsigned       TO_W       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0]   TO_MAX     = TO_W'(TIMEOUT_CYC);
    localparam logic [CNT_W:0]    SETTLE_LIM = (CNT_W + 1)'(SETTLE_CYC);

    bus_sample_t      bus_m, bus_s, bus_p;
    cap_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic [TO_W-1:0]  to_cnt;
    logic [3:0]       act, act_p, seen, seen_nxt;
    logic             single, coll, coll_p, changed, dig_chg, settle_hit, reeval;
    logic             capture_c, sel_err_c;
    logic [6:0]       seg_dec;
    logic [3:0]       dec_bcd;
    logic             dec_valid;
    logic [1:0]       idx;

    // Two-stage synchronizer plus a one-cycle history for change detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_m <= BUS_BLANK;
            bus_s <= BUS_BLANK;
            bus_p <= BUS_BLANK;
        end else begin
            bus_m <= '{seg: seg_in, dig: dig_in};
            bus_s <= bus_m;
            bus_p <= bus_s;
        end
    end

    assign act        = ~bus_s.dig;
    assign act_p      = ~bus_p.dig;
    assign single     = (act != 4'd0) && ((act & (act - 4'd1)) == 4'd0);
    assign coll       = (act != 4'd0) && !single;
    assign coll_p     = (act_p != 4'd0) && ((act_p & (act_p - 4'd1)) != 4'd0);
    assign changed    = (bus_s != bus_p);
    assign dig_chg    = (bus_s.dig != bus_p.dig);
    assign cnt_inc    = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
    assign settle_hit = ({1'b0, cnt} + (CNT_W + 1)'(1)) >= SETTLE_LIM;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        reeval    = 1'b0;
        case (state)
            ST_IDLE:   reeval = 1'b1;
            ST_SETTLE: begin
                if (changed) begin
                    reeval = 1'b1;
                end else begin
                    cnt_nxt = cnt_inc;
                    if (settle_hit) state_nxt = ST_DONE;
                end
            end
            ST_DONE:   if (dig_chg) reeval = 1'b1;
            default:   state_nxt = ST_IDLE;
        endcase
        // A fresh single enable starts a slot; blank or collision parks in IDLE.
        if (reeval) begin
            if (single) begin
                cnt_nxt   = CNT_W'(1);
                state_nxt = (SETTLE_CYC <= 1) ? ST_DONE : ST_SETTLE;
            end else begin
                cnt_nxt   = '0;
                state_nxt = ST_IDLE;
            end
        end
    end

    always_comb begin
        capture_c = (state != ST_DONE) && (state_nxt == ST_DONE);
        sel_err_c = coll && !coll_p;
    end

    assign seg_dec = (SEG_ACT_LOW != 0) ? ~bus_s.seg : bus_s.seg;
    assign idx     = onehot_to_idx(act);

    seg7_to_bcd u_dec (
        .seg     (seg_dec),
        .bcd_c   (dec_bcd),
        .valid_c (dec_valid)
    );

    assign seen_nxt = seen | act;

    always_ff @(posedge clk) begin
        if (rst) begin
            dig_val    <= 16'hFFFF;
            dig_ok     <= '0;
            frame_done <= 1'b0;
            pat_err    <= 1'b0;
            sel_err    <= 1'b0;
            seen       <= '0;
        end else begin
            frame_done <= 1'b0;
            pat_err    <= 1'b0;
            sel_err    <= sel_err_c;
            if (capture_c) begin
                dig_val[{idx, 2'b00} +: 4] <= dec_valid ? dec_bcd : DIG_BAD;
                if (dec_valid) dig_ok[idx] <= 1'b1;
                pat_err <= !dec_valid;
                if (seen_nxt == 4'hF) begin
                    frame_done <= 1'b1;
                    seen       <= '0;
                end else begin
                    seen <= seen_nxt;
                end
            end
        end
    end

    // Staleness: cycles since the last capture, saturating at the timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt <= '0;
            stale  <= 1'b0;
        end else if (capture_c) begin
            to_cnt <= '0;
            stale  <= 1'b0;
        end else if (to_cnt != TO_MAX) begin
            to_cnt <= to_cnt + TO_W'(1);
            stale  <= ((to_cnt + TO_W'(1)) == TO_MAX);
        end
    end

endmodule

// File: tb/tb_mux_7seg_capture.sv
// Directed bench for mux_7seg_capture: a run-length behavioural model is compared
// against the DUT every cycle, plus literal expectations per scenario.
module tb_mux_7seg_capture;

    localparam int unsigned SETTLE  = 4;
    localparam int unsigned TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  seg_in = 7'h00;
    logic [3:0]  dig_in = 4'hF;
    logic [15:0] dig_val;
    logic [3:0]  dig_ok;
    logic        frame_done, pat_err, sel_err, stale;

    always #5 clk = ~clk;

    mux_7seg_capture #(
        .SETTLE_CYC  (SETTLE),
        .TIMEOUT_CYC (TIMEOUT),
        .SEG_ACT_LOW (0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .seg_in     (seg_in),
        .dig_in     (dig_in),
        .dig_val    (dig_val),
        .dig_ok     (dig_ok),
        .frame_done (frame_done),
        .pat_err    (pat_err),
        .sel_err    (sel_err),
        .stale      (stale)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] model_decode(input logic [6:0] p);
        logic [6:0] tbl [0:9];
        tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        for (int i = 0; i < 10; i++) if (p == tbl[i]) return 4'(i);
        return 4'hF;
    endfunction

    // Model: inputs appear two edges late; a slot is captured once, when the synced
    // bus (one enable low) has been identical for SETTLE consecutive edges.
    bit          m_ready = 1'b0;
    logic [3:0]  m_d1, m_d2, m_px;
    logic [6:0]  m_s1, m_s2, m_pseg;
    int          m_run, m_cyc = 0, m_last_cap, m_caps = 0;
    bit          m_capd;
    logic [3:0]  m_seen;
    logic [15:0] e_val;
    logic [3:0]  e_ok;
    logic        e_fd, e_pe, e_se, e_stale;

    always @(posedge clk) begin
        logic [3:0] x, code;
        logic [6:0] s;
        int         pos;
        m_cyc++;
        if (rst) begin
            m_ready = 1'b1;
            m_d1 = 4'hF; m_d2 = 4'hF; m_px = 4'hF;
            m_s1 = 7'h00; m_s2 = 7'h00; m_pseg = 7'h00;
            m_run = 0; m_capd = 1'b0; m_seen = 4'h0; m_last_cap = m_cyc;
            e_val = 16'hFFFF; e_ok = 4'h0;
            e_fd = 1'b0; e_pe = 1'b0; e_se = 1'b0; e_stale = 1'b0;
        end else begin
            x = m_d2; s = m_s2;
            e_fd = 1'b0; e_pe = 1'b0; e_se = 1'b0;
            if (x != m_px || s != m_pseg) m_run = 1; else m_run++;
            if (x != m_px) m_capd = 1'b0;
            if ($countones(~x) >= 2 && $countones(~m_px) < 2) e_se = 1'b1;
            if ($countones(~x) == 1 && !m_capd && m_run == int'(SETTLE)) begin
                pos = 0;
                for (int i = 0; i < 4; i++) if (!x[i]) pos = i;
                code = model_decode(s);
                e_val[pos*4 +: 4] = code;
                if (code != 4'hF) e_ok[pos] = 1'b1;
                e_pe = (code == 4'hF);
                m_seen[pos] = 1'b1;
                if (m_seen == 4'hF) begin
                    e_fd = 1'b1;
                    m_seen = 4'h0;
                end
                m_capd = 1'b1;
                m_last_cap = m_cyc;
                m_caps++;
            end
            e_stale = ((m_cyc - m_last_cap) >= int'(TIMEOUT));
            m_px = x; m_pseg = s;
            m_d2 = m_d1; m_d1 = dig_in;
            m_s2 = m_s1; m_s1 = seg_in;
        end
    end

    int n_fd = 0, n_pe = 0, n_se = 0;
    bit test2_on = 1'b0, saw3 = 1'b0;

    always @(negedge clk) begin
        if (m_ready) begin
            check("dig_val",    32'(dig_val),    32'(e_val));
            check("dig_ok",     32'(dig_ok),     32'(e_ok));
            check("frame_done", 32'(frame_done), 32'(e_fd));
            check("pat_err",    32'(pat_err),    32'(e_pe));
            check("sel_err",    32'(sel_err),    32'(e_se));
            check("stale",      32'(stale),      32'(e_stale));
            n_fd += int'(frame_done);
            n_pe += int'(pat_err);
            n_se += int'(sel_err);
            if (test2_on && dig_val[3:0] == 4'd3) saw3 = 1'b1;
        end
    end

    task automatic drive(input logic [3:0] d, input logic [6:0] s, input int n);
        dig_in = d;
        seg_in = s;
        repeat (n) @(negedge clk);
    endtask

    int base;

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset dig_val", 32'(dig_val), 32'h0000FFFF);
        check("reset dig_ok",  32'(dig_ok),  32'h0);
        check("reset stale",   32'(stale),   32'h0);

        // Full frame of four valid digits
        drive(4'hE, 7'h3F, 12);
        drive(4'hD, 7'h5B, 12);
        drive(4'hB, 7'h06, 12);
        drive(4'h7, 7'h6F, 12);
        drive(4'hF, 7'h00, 8);
        #1;
        check("t1 dig_val",    32'(dig_val), 32'h00009120);
        check("t1 dig_ok",     32'(dig_ok),  32'hF);
        check("t1 frame_done", 32'(n_fd),    32'd1);
        check("t1 pat_err",    32'(n_pe),    32'd0);
        check("t1 sel_err",    32'(n_se),    32'd0);

        // Segment change before settling: only the settled value is taken
        base = m_caps;
        test2_on = 1'b1;
        drive(4'hE, 7'h4F, 3);
        drive(4'hE, 7'h66, 12);
        drive(4'hF, 7'h00, 8);
        test2_on = 1'b0;
        #1;
        check("t2 d0",       32'(dig_val[3:0]), 32'd4);
        check("t2 never 3",  32'(saw3),         32'd0);
        check("t2 one latch", 32'(m_caps - base), 32'd1);

        // Two enables low at once
        base = n_se;
        drive(4'hC, 7'h3F, 10);
        drive(4'hF, 7'h00, 8);
        #1;
        check("t3 sel_err once", 32'(n_se - base), 32'd1);
        check("t3 dig_val",      32'(dig_val),     32'h00009124);

        // Undecodable pattern on digit 1
        base = n_pe;
        drive(4'hD, 7'h49, 12);
        drive(4'hF, 7'h00, 8);
        #1;
        check("t4 dig_val",     32'(dig_val),     32'h000091F4);
        check("t4 dig_ok",      32'(dig_ok),      32'hF);
        check("t4 pat_err once", 32'(n_pe - base), 32'd1);
        check("t4 not stale",   32'(stale),       32'd0);

        // Bus idle long enough to go stale, then a valid slot recovers
        drive(4'hF, 7'h00, 62);
        #1;
        check("t5 stale", 32'(stale), 32'd1);
        drive(4'hB, 7'h7D, 12);
        #1;
        check("t5 stale cleared", 32'(stale),   32'd0);
        check("t5 dig_val",       32'(dig_val), 32'h000096F4);

        // Reset in the middle of a settling slot
        drive(4'h7, 7'h07, 4);
        rst = 1'b1;
        drive(4'hF, 7'h00, 1);
        #1;
        rst = 1'b0;
        check("t6 reset dig_val", 32'(dig_val),    32'h0000FFFF);
        check("t6 reset dig_ok",  32'(dig_ok),     32'h0);
        check("t6 reset stale",   32'(stale),      32'h0);
        check("t6 reset pulses",  32'({frame_done, pat_err, sel_err}), 32'h0);
        base = n_fd;
        drive(4'hF, 7'h00, 6);
        #1;
        check("t6 no capture", 32'(dig_val), 32'h0000FFFF);
        drive(4'h7, 7'h07, 12);
        drive(4'hF, 7'h00, 4);
        #1;
        check("t6 resume dig_val", 32'(dig_val),    32'h00007FFF);
        check("t6 resume dig_ok",  32'(dig_ok),     32'h8);
        check("t6 no frame",       32'(n_fd - base), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
